dff_async_bist: RTL

Self-checking hardware stimulus/response block for the asynchronous-reset D flip-flop (`dff_async`). It drives the flip-flop's data and reset inputs with a deterministic pseudo-random sequence. It checks the returned `q`/`qb` against an internal reference model each vector and reports pass/fail counts. It sits beside `dff_async` as the on-chip counterpart of the simulation bench, so the same check can run on silicon or in FPGA bring-up.

---
 rtl/dff_async_bist_pkg.sv | 29 ++
 rtl/dff_async_bist_lfsr16.sv | 28 ++
 rtl/dff_async_bist.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dff_async_bist_pkg.sv
// Shared types and constants for the dff_async built-in self-test block:
// FSM state encoding, LFSR geometry/taps, default seed and LFSR helpers.
package dff_async_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned LFSR_W = 16;

    // x^16 + x^14 + x^13 + x^11 + 1, left-shifting Fibonacci: bits 15, 13, 12, 10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    // Feedback bit that enters bit 0 on the next shift.
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] v);
        return ^(v & LFSR_TAPS);
    endfunction

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    function automatic logic [LFSR_W-1:0] lfsr_fix_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction

endpackage

// File: rtl/dff_async_bist_lfsr16.sv
// 16-bit left-shifting Fibonacci LFSR with synchronous load and step.
// Ports: clk, reset (async, active-low), load (take seed), seed,
//        step (advance one position), value (current state).
module lfsr16
    import dff_async_bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VALUE = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    // Load has priority over step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= RESET_VALUE;
        end else if (load) begin
            value <= seed;
        end else if (step) begin
            value <= {value[LFSR_W-2:0], lfsr_fb(value)};
        end
    end

endmodule

// File: rtl/dff_async_bist.sv
// Built-in self-test for the asynchronous-reset D flip-flop. Drives an
// LFSR-derived d/reset vector for one cycle, checks q/qb the next cycle,
// and accumulates saturating pass/fail counts.
// Ports: clk, reset (async, active-low), i_start (run pulse),
//        i_q/i_qb (DUT outputs), o_d/o_dut_reset (DUT inputs),
//        o_busy, o_done, o_pass_cnt, o_fail_cnt, o_all_pass.
module dff_async_bist
    import dff_async_bist_pkg::*;
#(
    parameter int unsigned       NUM_VECTORS = 100,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = DEFAULT_SEED,
    parameter int unsigned       CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_q,
    input  logic             i_qb,
    output logic             o_d,
    output logic             o_dut_reset,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic             o_all_pass
);

    localparam int unsigned       IDX_W    = 16;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [LFSR_W-1:0] SEED_EFF = lfsr_fix_seed(LFSR_SEED);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [LFSR_W-1:0]  lfsr_val;
    logic               lfsr_load;
    logic               lfsr_step_en;
    logic               d_nxt;
    logic               dut_reset_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               all_pass_nxt;
    logic [CNT_W-1:0]   pass_nxt;
    logic [CNT_W-1:0]   fail_nxt;
    logic               exp_q;
    logic               vec_ok;
    logic               last_vec;

    lfsr16 #(
        .RESET_VALUE (SEED_EFF)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .seed  (SEED_EFF),
        .step  (lfsr_step_en),
        .value (lfsr_val)
    );

    // The registered vector is still on o_d/o_dut_reset during CHECK.
    assign exp_q    = o_dut_reset ? 1'b0 : o_d;
    assign vec_ok   = (i_q == exp_q) && (i_qb == ~i_q);
    assign last_vec = (idx >= LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (i_start) state_nxt = ST_DRIVE;
            ST_DRIVE:         state_nxt = ST_CHECK;
            ST_CHECK:         state_nxt = last_vec ? ST_DONE : ST_DRIVE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values, registered below.
    always_comb begin
        idx_nxt       = idx;
        d_nxt         = o_d;
        dut_reset_nxt = o_dut_reset;
        busy_nxt      = o_busy;
        done_nxt      = o_done;
        all_pass_nxt  = o_all_pass;
        pass_nxt      = o_pass_cnt;
        fail_nxt      = o_fail_cnt;
        lfsr_load     = 1'b0;
        lfsr_step_en  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    // The LFSR loads at this same edge, so vector 0 comes straight from the seed.
                    lfsr_load     = 1'b1;
                    idx_nxt       = '0;
                    pass_nxt      = '0;
                    fail_nxt      = '0;
                    d_nxt         = SEED_EFF[0];
                    dut_reset_nxt = SEED_EFF[1] & SEED_EFF[2];
                    busy_nxt      = 1'b1;
                    done_nxt      = 1'b0;
                    all_pass_nxt  = 1'b0;
                end
            end
            ST_CHECK: begin
                lfsr_step_en = 1'b1;
                if (vec_ok) begin
                    if (o_pass_cnt != CNT_MAX) pass_nxt = o_pass_cnt + CNT_W'(1);
                end else begin
                    if (o_fail_cnt != CNT_MAX) fail_nxt = o_fail_cnt + CNT_W'(1);
                end
                if (!last_vec) begin
                    // Bits 0..2 of the stepped LFSR, without materialising the full next state.
                    idx_nxt       = idx + IDX_W'(1);
                    d_nxt         = lfsr_fb(lfsr_val);
                    dut_reset_nxt = lfsr_val[0] & lfsr_val[1];
                end else begin
                    d_nxt         = 1'b0;
                    dut_reset_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    done_nxt      = 1'b1;
                    all_pass_nxt  = (fail_nxt == '0);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and vector index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            o_d         <= 1'b0;
            o_dut_reset <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass_cnt  <= '0;
            o_fail_cnt  <= '0;
            o_all_pass  <= 1'b0;
        end else begin
            idx         <= idx_nxt;
            o_d         <= d_nxt;
            o_dut_reset <= dut_reset_nxt;
            o_busy      <= busy_nxt;
            o_done      <= done_nxt;
            o_pass_cnt  <= pass_nxt;
            o_fail_cnt  <= fail_nxt;
            o_all_pass  <= all_pass_nxt;
        end
    end

endmodule
